hazard_fwd_unit: RTL

//   Central hazard unit of the 5-stage pipeline; drives the select inputs of
//   the EX-stage 3:1 operand muxes (encoding 00 = ID/EX register value,
//   01 = WB result, 10 = MEM ALU result; 11 unused, treated as 10 by the mux).

---
 rtl/hazard_fwd_unit.sv | 136 +++++++++++++
 1 files changed

// File: rtl/hazard_fwd_unit.sv
// Hazard and forwarding unit for the 5-stage pipeline: load-use stall/bubble
// control, registered EX operand forwarding selects and a saturating stall counter.
module hazard_fwd_unit #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regwrite,
    input  logic             id_memtoreg,
    input  logic             flush,
    output logic             stall,
    output logic             bubble_e,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [1:0]       SEL_REG  = 2'b00;
    localparam logic [1:0]       SEL_WB   = 2'b01;
    localparam logic [1:0]       SEL_MEM  = 2'b10;
    localparam logic [REG_W-1:0] REG_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Shadow of the destination info held by the EX and MEM stages. The WB
    // stage needs no shadow because the register file is write-through.
    logic             ex_v;
    logic [REG_W-1:0] ex_rd;
    logic             ex_rw;
    logic             ex_ld;
    logic             mem_v;
    logic [REG_W-1:0] mem_rd;
    logic             mem_rw;

    logic             lu;
    logic             accept;
    logic [1:0]       sel_a;
    logic [1:0]       sel_b;

    // The youngest producer wins; a load in EX cannot forward yet, so it
    // falls through to whatever MEM holds.
    function automatic logic [1:0] fwd_select(
        input logic [REG_W-1:0] r,
        input logic             used,
        input logic             e_v,
        input logic [REG_W-1:0] e_rd,
        input logic             e_rw,
        input logic             e_ld,
        input logic             m_v,
        input logic [REG_W-1:0] m_rd,
        input logic             m_rw
    );
        logic ex_hit;
        logic mem_hit;
        logic [1:0] sel;
        ex_hit  = e_v & e_rw & (e_rd == r) & (r != REG_ZERO);
        mem_hit = m_v & m_rw & (m_rd == r) & (r != REG_ZERO);
        sel = SEL_REG;
        if (used) begin
            if (ex_hit & ~e_ld)
                sel = SEL_MEM;
            else if (mem_hit)
                sel = SEL_WB;
        end
        return sel;
    endfunction

    always_comb begin
        lu = id_valid & ex_v & ex_ld & ex_rw & (ex_rd != REG_ZERO) &
             ((id_rs_used & (ex_rd == id_rs)) | (id_rt_used & (ex_rd == id_rt)));
        stall    = lu & ~flush;
        bubble_e = lu | flush;
        accept   = id_valid & ~bubble_e;
        sel_a = fwd_select(id_rs, id_rs_used, ex_v, ex_rd, ex_rw, ex_ld,
                           mem_v, mem_rd, mem_rw);
        sel_b = fwd_select(id_rt, id_rt_used, ex_v, ex_rd, ex_rw, ex_ld,
                           mem_v, mem_rd, mem_rw);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_v  <= 1'b0;
            ex_rd <= REG_ZERO;
            ex_rw <= 1'b0;
            ex_ld <= 1'b0;
        end else if (accept) begin
            ex_v  <= 1'b1;
            ex_rd <= id_rd;
            ex_rw <= id_regwrite;
            ex_ld <= id_memtoreg;
        end else begin
            ex_v  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_v  <= 1'b0;
            mem_rd <= REG_ZERO;
            mem_rw <= 1'b0;
        end else begin
            mem_v  <= ex_v;
            mem_rd <= ex_rd;
            mem_rw <= ex_rw;
        end
    end

    // Selects travel with the instruction into EX; a bubble carries 00.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_a <= SEL_REG;
            fwd_b <= SEL_REG;
        end else if (accept) begin
            fwd_a <= sel_a;
            fwd_b <= sel_b;
        end else begin
            fwd_a <= SEL_REG;
            fwd_b <= SEL_REG;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_count <= '0;
        else if (stall && (stall_count != CNT_MAX))
            stall_count <= stall_count + CNT_ONE;
    end

endmodule
